audvid_clock_divider: RTL and testbench
=======================================

// Module: audvid_clock_divider
// PURPOSE
//  - NUM_CH-channel programmable integer clock divider on a single MMCM output clock.
//  - Per channel: a divided square wave plus a one-cycle clock-enable strobe on each rising edge.
//  - Outputs stay silent until the MMCM Locked input has been seen for LOCK_STAGES cycles.
//  - Divisors are reloadable at runtime without glitches, and channels can be phase-aligned with Sync.
//  - Sits after the MMCM stage; feeds I2S and TFT clocking and the audio/video enable logic.
// PARAMETERS
//  NUM_CH       3    number of independent divider channels
//  DIV_W        16   divisor / counter width per channel
//  LOCK_STAGES  8    depth of Locked qualification shift register (>=2)
//  DEFAULT_DIV  10   divisor loaded into every channel at reset (>=2)
// PORTS
//  InputCLK   in   1             single clock; all logic on posedge
//  Reset      in   1             asynchronous, active-high reset
//  Locked     in   1             MMCM lock status, asynchronous to InputCLK
//  ChEnable   in   NUM_CH        per-channel run enable
//  DivLoad    in   NUM_CH        per-channel one-cycle load strobe
//  DivValue   in   NUM_CH*DIV_W  channel i divisor at [i*DIV_W +: DIV_W]
//  Sync       in   1             one-cycle strobe: restart all channels in phase
//  Ready      out  1             qualified lock; high = outputs running
//  ClkOut     out  NUM_CH        divided clocks, registered
//  ClkEn      out  NUM_CH        one-cycle strobe, high in each ClkOut-rising cycle
// BEHAVIOUR
//  - Reset (async, any time, including mid-period) forces:
//    - lock chain = 0, Ready = 0
//    - all cnt = 0, ClkOut = 0, ClkEn = 0
//    - active D = DEFAULT_DIV, pending-valid = 0
//  - Lock qualifier: Locked shifts into a LOCK_STAGES-bit register each cycle; Ready = last stage.
//    - Ready rises exactly LOCK_STAGES cycles after Locked is first sampled high.
//    - Ready falls LOCK_STAGES cycles after Locked is sampled low.
//  - Gating: while Ready=0 or ChEnable[i]=0, channel i holds cnt=0, ClkOut=0, ClkEn=0.
//    - The first period after gating is released starts at cnt=0.
//  - Divisor rules: effective D = max(DivValue, 2); DivValue 0 or 1 is clamped to 2.
//    - H = D>>1 cycles high; D-H cycles low.
//  - Counter: cnt steps 0..D-1, then wraps to 0.
//    - ClkOut and cnt update on the same edge; ClkOut = (cnt >= D-H).
//    - ClkEn = 1 only in the cycle where cnt == D-H.
//    - Example D=10: low for cnt 0..4, high for cnt 5..9.
//  - Reload: DivLoad[i] captures the value into pending[i] and sets pending-valid.
//    - A second load before it is applied overwrites (last wins).
//    - Pending is applied only at a wrap (cnt==D-1 -> 0), so the current period always completes.
//    - Load and wrap in the same cycle: the new value applies at that wrap.
//    - Pending loads are captured even while the channel is gated.
//  - Sync: next edge sets every channel cnt=0 and ClkOut=0, and applies any pending divisor at once.
//    - Sync takes priority over wrap and over normal counting.
//    - Ignored while Ready=0.
//  - Latency: ClkOut/ClkEn are registered with no additional pipeline stage.
//  - Arithmetic: unsigned DIV_W-bit; the compare D-H never underflows because D>=2.
// STRUCTURE
//  - Package audvid_clk_pkg:
//    - MIN_DIV = 2
//    - function hi_start(D) = D - (D>>1)
//    - DIV_W default constant
//  - Sub-module audvid_clk_div_channel: counter, pending register, ClkOut/ClkEn.
//    - One instance per channel via generate.
//  - Top level holds the lock qualifier and the Sync/Ready fan-out.
// TESTING
//  1. Reset, then Locked=1 at cycle 0 -> Ready=0 through cycle 7, Ready=1 at cycle 8.
//     ClkOut stays 0 until then.
//  2. Default D=10 on all channels -> each ClkOut has period 10, low 5 / high 5.
//     ClkEn fires once per period, coincident with each ClkOut rise.
//  3. DivValue=5 on ch1 -> high 2 cycles, low 3.
//     DivValue=0, then 1 -> D=2, ClkOut toggles every cycle, ClkEn every 2nd cycle.
//  4. D=10, DivLoad D=4 at cnt=3 -> current period still 10 cycles, next periods 4.
//     Second load D=6 before the wrap -> 6 wins.
//  5. ch0 D=6, ch1 D=9, Sync pulse -> both cnt=0 next cycle.
//     ch0 rises 3 cycles later, ch1 rises 5 cycles later.
//     Sync coincident with a wrap -> Sync wins.
//  6. Locked drops mid-run -> Ready falls 8 cycles later and all outputs go 0 that cycle.
//     Async Reset at cnt=7 -> outputs 0 immediately, D back to 10.

Source files
------------

// File: rtl/audvid_clk_pkg.sv
// Shared constants and helpers for the audio/video clock divider.
// The divider channels import this package.
package audvid_clk_pkg;

   localparam int DIV_W_DEF = 16;
   localparam int MIN_DIV   = 2;

   // First count of the high phase: the low phase takes the larger half of odd divisors.
   function automatic logic [31:0] hi_start(input logic [31:0] d);
      return d - (d >> 1);
   endfunction

endpackage

// File: rtl/audvid_clk_div_channel.sv
// One divider channel: counter, reloadable divisor with pending slot,
// and the registered divided clock plus its rising-edge enable strobe.
module audvid_clk_div_channel
   import audvid_clk_pkg::*;
#(
   parameter int DIV_W       = DIV_W_DEF,
   parameter int DEFAULT_DIV = 10
) (
   input  logic             MasterClocK_reloj1_clk_wiz_0_0_en_clk,
   input  logic             rst,
   input  logic             run,
   input  logic             sync,
   input  logic             load,
   input  logic [DIV_W-1:0] div_value,
   output logic             clk_out,
   output logic             clk_en
);

   function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
      return (v < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : v;
   endfunction

   logic [DIV_W-1:0] cnt, div_act, pend, pend_eff, hs, cnt_nxt;
   logic             pend_vld, pend_vld_eff, wrap, apply;

   // A load in the same cycle as a wrap or sync takes effect at that boundary.
   always_comb begin
      hs           = DIV_W'(hi_start(32'(div_act)));
      pend_eff     = load ? clamp_div(div_value) : pend;
      pend_vld_eff = load | pend_vld;
      wrap         = run && !sync && (cnt == div_act - DIV_W'(1));
      apply        = pend_vld_eff && (sync || wrap);
      if (sync || !run || wrap)
         cnt_nxt = '0;
      else
         cnt_nxt = cnt + DIV_W'(1);
   end

   always_ff @(posedge MasterClocK_reloj1_clk_wiz_0_0_en_clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         clk_out  <= 1'b0;
         clk_en   <= 1'b0;
         div_act  <= DIV_W'(DEFAULT_DIV);
         pend_vld <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         clk_out  <= (cnt_nxt >= hs);
         clk_en   <= (cnt_nxt == hs);
         if (apply)
            div_act <= pend_eff;
         pend_vld <= pend_vld_eff & ~apply;
      end
   end

   // Pending value is pure data; only its valid flag needs reset.
   always_ff @(posedge MasterClocK_reloj1_clk_wiz_0_0_en_clk) begin
      if (load)
         pend <= clamp_div(div_value);
   end

endmodule

// File: rtl/audvid_clock_divider.sv
// Multi-channel programmable clock divider behind the MMCM: lock qualification,
// Sync/Ready fan-out and one divider channel per output.
module audvid_clock_divider
   import audvid_clk_pkg::*;
#(
   parameter int NUM_CH      = 3,
   parameter int DIV_W       = DIV_W_DEF,
   parameter int LOCK_STAGES = 8,
   parameter int DEFAULT_DIV = 10
) (
   input  logic                    InputCLK,
   input  logic                    Reset,
   input  logic                    Locked,
   input  logic [NUM_CH-1:0]       ChEnable,
   input  logic [NUM_CH-1:0]       DivLoad,
   input  logic [NUM_CH*DIV_W-1:0] DivValue,
   input  logic                    Sync,
   output logic                    Ready,
   output logic [NUM_CH-1:0]       ClkOut,
   output logic [NUM_CH-1:0]       ClkEn
);

   logic [LOCK_STAGES-1:0] lock_sr;
   logic                   run_ok, sync_ok;

   // The shift chain also synchronises the asynchronous Locked input.
   always_ff @(posedge InputCLK or posedge Reset) begin
      if (Reset)
         lock_sr <= '0;
      else
         lock_sr <= {lock_sr[LOCK_STAGES-2:0], Locked};
   end

   assign Ready = lock_sr[LOCK_STAGES-1];
   // The next stage down is what Ready becomes after this edge, so channels
   // are already silent in the first cycle that Ready reads low.
   assign run_ok  = lock_sr[LOCK_STAGES-1] & lock_sr[LOCK_STAGES-2];
   assign sync_ok = Sync & Ready;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      audvid_clk_div_channel #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .MasterClocK_reloj1_clk_wiz_0_0_en_clk (InputCLK),
         .rst        (Reset),
         .run        (run_ok & ChEnable[i]),
         .sync       (sync_ok),
         .load       (DivLoad[i]),
         .div_value  (DivValue[i*DIV_W +: DIV_W]),
         .clk_out    (ClkOut[i]),
         .clk_en     (ClkEn[i])
      );
   end

endmodule

// File: tb/tb_audvid_clock_divider.sv
// Testbench for audvid_clock_divider: directed table and corner sequences
// plus randomized traffic against a phase-based reference model.
module tb_audvid_clock_divider;

   localparam int NCH = 3;
   localparam int DW  = 16;
   localparam int LS  = 8;
   localparam int DEF = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              locked;
   logic [NCH-1:0]    chen;
   logic [NCH-1:0]    dload;
   logic [NCH*DW-1:0] dval;
   logic              sync;
   logic              ready;
   logic [NCH-1:0]    clk_out;
   logic [NCH-1:0]    clk_en;

   int n_tests = 0;
   int n_fail  = 0;

   audvid_clock_divider #(
      .NUM_CH(NCH), .DIV_W(DW), .LOCK_STAGES(LS), .DEFAULT_DIV(DEF)
   ) dut (
      .InputCLK(clk), .Reset(rst), .Locked(locked), .ChEnable(chen),
      .DivLoad(dload), .DivValue(dval), .Sync(sync),
      .Ready(ready), .ClkOut(clk_out), .ClkEn(clk_en)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, idx, $time, act, exp);
      end
   endtask

   // Reference model: each channel is a phase within its current period.
   // Ready is the Locked sample taken LS edges back.
   int m_p[NCH];
   int m_d[NCH];
   int m_pend[NCH];
   bit m_pv[NCH];
   bit lq[$];

   function automatic bit m_ready();
      return (lq.size() == LS) ? lq[0] : 1'b0;
   endfunction

   function automatic void m_reset();
      lq.delete();
      for (int i = 0; i < NCH; i++) begin
         m_p[i] = 0; m_d[i] = DEF; m_pv[i] = 1'b0; m_pend[i] = DEF;
      end
   endfunction

   function automatic void m_step();
      bit rc, rn;
      int v;
      rc = m_ready();
      lq.push_back(locked);
      if (lq.size() > LS) void'(lq.pop_front());
      rn = m_ready();
      for (int i = 0; i < NCH; i++) begin
         v = int'(dval[i*DW +: DW]);
         if (v < 2) v = 2;
         if (dload[i]) begin m_pend[i] = v; m_pv[i] = 1'b1; end
         if (sync && rc) begin
            m_p[i] = 0;
            if (m_pv[i]) begin m_d[i] = m_pend[i]; m_pv[i] = 1'b0; end
         end else if (rc && rn && chen[i]) begin
            if (m_p[i] == m_d[i] - 1) begin
               m_p[i] = 0;
               if (m_pv[i]) begin m_d[i] = m_pend[i]; m_pv[i] = 1'b0; end
            end else
               m_p[i]++;
         end else
            m_p[i] = 0;
      end
   endfunction

   always @(posedge clk) begin
      if (rst) m_reset();
      else     m_step();
   end

   always @(negedge clk) begin
      if (rst) m_reset();
      chk("model_ready", 0, 32'(ready), 32'(m_ready()));
      for (int i = 0; i < NCH; i++) begin
         chk("model_clkout", i, 32'(clk_out[i]), 32'(m_p[i] >= m_d[i] - m_d[i] / 2));
         chk("model_clken",  i, 32'(clk_en[i]),  32'(m_p[i] == m_d[i] - m_d[i] / 2));
      end
   end

   // ---- driver helpers (all called at a negedge, return at a negedge) ----
   task automatic load_div(input int ch, input int v);
      dval[ch*DW +: DW] = DW'(v);
      dload[ch] = 1'b1;
      @(negedge clk);
      dload[ch] = 1'b0;
   endtask

   task automatic do_sync();
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
   endtask

   task automatic measure(input int ch, output int hi, output int lo);
      int w;
      w = 0; hi = 0; lo = 0;
      while (!clk_en[ch] && w < 100) begin @(negedge clk); w++; end
      while (clk_out[ch] && hi < 100) begin hi++; @(negedge clk); end
      while (!clk_out[ch] && lo < 100) begin lo++; @(negedge clk); end
   endtask

   task automatic collect_en(input int ch, input int c0, output int e0, output int e1, output int e2);
      int c, n;
      int e[3];
      e = '{-1, -1, -1};
      c = c0; n = 0;
      while (c <= c0 + 40 && n < 3) begin
         if (clk_en[ch]) begin e[n] = c; n++; end
         if (n < 3) begin @(negedge clk); c++; end
      end
      e0 = e[0]; e1 = e[1]; e2 = e[2];
   endtask

   task automatic first_en2(output int f0, output int f1);
      f0 = -1; f1 = -1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (clk_en[0] && f0 < 0) f0 = c;
         if (clk_en[1] && f1 < 0) f1 = c;
      end
   endtask

   task automatic wait_ready();
      int w;
      w = 0;
      while (!ready && w < 50) begin @(negedge clk); w++; end
      chk("wait_ready", 0, 32'(ready), 32'd1);
   endtask

   typedef struct {
      int ch;
      int val;
      int hi;
      int lo;
   } vec_t;

   initial begin
      vec_t tbl[7];
      int hi, lo, e0, e1, e2, f0, f1;

      rst = 1'b1; locked = 1'b0; chen = '1; dload = '0; dval = '0; sync = 1'b0;
      tbl[0] = '{1, 5, 2, 3};
      tbl[1] = '{1, 0, 1, 1};
      tbl[2] = '{1, 1, 1, 1};
      tbl[3] = '{2, 2, 1, 1};
      tbl[4] = '{2, 3, 1, 2};
      tbl[5] = '{0, 9, 4, 5};
      tbl[6] = '{0, 7, 3, 4};

      repeat (3) @(negedge clk);
      chk("rst_ready", 0, 32'(ready), 0);
      chk("rst_clkout", 0, 32'(clk_out), 0);
      chk("rst_clken", 0, 32'(clk_en), 0);

      // Lock qualification from cycle 0
      rst = 1'b0;
      locked = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         chk("lock_ready", k, 32'(ready), 32'(k >= LS));
         chk("lock_clkout", k, 32'(clk_out), 0);
      end

      for (int i = 0; i < NCH; i++) begin
         measure(i, hi, lo);
         chk("def_hi", i, hi, 5);
         chk("def_lo", i, lo, 5);
      end

      for (int t = 0; t < 7; t++) begin
         load_div(tbl[t].ch, tbl[t].val);
         do_sync();
         measure(tbl[t].ch, hi, lo);
         chk("tbl_hi", t, hi, tbl[t].hi);
         chk("tbl_lo", t, lo, tbl[t].lo);
      end

      // Reload mid-period: current period completes, then new divisor
      load_div(0, 10);
      do_sync();
      repeat (3) @(negedge clk);
      load_div(0, 4);
      collect_en(0, 4, e0, e1, e2);
      chk("reload_en0", 0, e0, 5);
      chk("reload_en1", 0, e1, 12);
      chk("reload_en2", 0, e2, 16);
      load_div(0, 10);
      do_sync();
      repeat (3) @(negedge clk);
      load_div(0, 4);
      load_div(0, 6);
      collect_en(0, 5, e0, e1, e2);
      chk("lastwins_en0", 0, e0, 5);
      chk("lastwins_en1", 0, e1, 13);
      chk("lastwins_en2", 0, e2, 19);

      // Sync phase alignment, then Sync on ch1's wrap cycle
      load_div(0, 6);
      load_div(1, 9);
      do_sync();
      first_en2(f0, f1);
      chk("sync_ch0", 0, f0, 3);
      chk("sync_ch1", 1, f1, 5);
      do_sync();
      repeat (8) @(negedge clk);
      do_sync();
      first_en2(f0, f1);
      chk("syncwrap_ch0", 0, f0, 3);
      chk("syncwrap_ch1", 1, f1, 5);

      // Locked drop
      locked = 1'b0;
      for (int k = 1; k <= LS; k++) begin
         @(negedge clk);
         if (k == LS - 1) chk("drop_ready_hi", k, 32'(ready), 1);
         if (k == LS) begin
            chk("drop_ready_lo", k, 32'(ready), 0);
            chk("drop_clkout", k, 32'(clk_out), 0);
            chk("drop_clken", k, 32'(clk_en), 0);
         end
      end
      locked = 1'b1;
      wait_ready();

      // Async reset mid-period
      load_div(0, 4);
      load_div(1, 10);
      do_sync();
      repeat (7) @(negedge clk);
      chk("pre_rst_clkout1", 1, 32'(clk_out[1]), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_clkout", 0, 32'(clk_out), 0);
      chk("async_rst_clken", 0, 32'(clk_en), 0);
      chk("async_rst_ready", 0, 32'(ready), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_ready();
      measure(0, hi, lo);
      chk("post_rst_hi", 0, hi, 5);
      chk("post_rst_lo", 0, lo, 5);

      // Randomized traffic, checked every cycle by the model
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 299) == 0) locked = ~locked;
         if ($urandom_range(0, 49) == 0) chen = NCH'($urandom);
         for (int i = 0; i < NCH; i++) begin
            dload[i] = ($urandom_range(0, 15) == 0);
            dval[i*DW +: DW] = DW'($urandom_range(0, 20));
         end
         sync = ($urandom_range(0, 39) == 0);
      end
      @(negedge clk);
      dload = '0; sync = 1'b0; locked = 1'b1;
      repeat (5) @(negedge clk);

      @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
